// File: rtl/qbus_slave_sequencer.sv
// qbus_slave_sequencer: synchronises QBUS slave strobes and turns DATI/DATO/DATIO cycles into single-cycle register strobes
module qbus_slave_sequencer #(
  parameter logic [21:0] ADDR = 22'o777777,
  parameter int COUNT = 1,
  parameter int IW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          RSYNC,
  input  logic          RDIN,
  input  logic          RDOUT,
  input  logic          RBS7,
  input  logic [21:0]   DAL_in,
  output logic [21:0]   DAL_out,
  output logic          DALtx,
  output logic          TRPLY,
  output logic [IW-1:0] reg_index,
  output logic          reg_rd,
  output logic          reg_wr,
  output logic [15:0]   reg_wdata,
  input  logic [15:0]   reg_rdata,
  input  logic          reg_ack
);
  typedef enum logic [2:0] {IDLE, SEL, RD, RDRV, WR, WRPLY, SKIP} state_t;
  localparam logic [11:0] BASE = ADDR[12:1];
  localparam logic [11:0] CNT = 12'(COUNT);
  state_t state;
  logic s_sync_m, s_sync, s_sync_d, s_din_m, s_din, s_dout_m, s_dout;
  logic armed, wr_done, bs7, hit, unused_dal;
  logic [1:0] vld;
  logic [11:0] addr, diff;
  assign diff = addr - BASE;
  assign hit = bs7 && diff < CNT;
  assign unused_dal = ^DAL_in[21:16];
  // armed only after seeing SYNC low once the synchronisers reflect the real bus
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {s_sync_m, s_sync, s_sync_d, s_din_m, s_din, s_dout_m, s_dout} <= '0;
      vld <= '0;
      armed <= 1'b0;
      bs7 <= 1'b0;
      addr <= '0;
    end else begin
      {s_sync_d, s_sync, s_sync_m} <= {s_sync, s_sync_m, RSYNC};
      {s_din, s_din_m} <= {s_din_m, RDIN};
      {s_dout, s_dout_m} <= {s_dout_m, RDOUT};
      vld <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & ~s_sync);
      if (!RSYNC) {bs7, addr} <= {RBS7, DAL_in[12:1]};
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      wr_done <= 1'b0;
      DALtx <= 1'b0;
      TRPLY <= 1'b0;
      DAL_out <= '0;
      reg_wdata <= '0;
      reg_index <= '0;
    end else begin
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      if (!s_sync && state != IDLE) begin
        state <= IDLE;
        DALtx <= 1'b0;
        TRPLY <= 1'b0;
      end else
        case (state)
          IDLE: if (armed && s_sync && !s_sync_d) state <= SEL;
          SEL:
            if (!hit) state <= SKIP;
            else if (s_din) begin
              state <= RD;
              reg_rd <= 1'b1;
              reg_index <= diff[IW-1:0];
            end else if (s_dout) begin
              state <= WR;
              wr_done <= 1'b0;
              reg_wdata <= DAL_in[15:0];
              reg_index <= diff[IW-1:0];
            end
          RD:
            if (reg_ack) begin
              state <= RDRV;
              DAL_out <= {6'b0, reg_rdata};
              DALtx <= 1'b1;
              TRPLY <= 1'b1;
            end
          RDRV:
            if (!s_din) begin
              state <= SEL;
              DALtx <= 1'b0;
              TRPLY <= 1'b0;
            end
          WR:
            if (!wr_done) begin
              reg_wr <= 1'b1;
              wr_done <= 1'b1;
            end else if (reg_ack) begin
              state <= WRPLY;
              TRPLY <= 1'b1;
            end
          WRPLY:
            if (!s_dout) begin
              state <= SKIP;
              TRPLY <= 1'b0;
            end
          default: state <= state;
        endcase
    end
endmodule

// File: tb/tb_qbus_slave_sequencer.sv
// tb_qbus_slave_sequencer: directed bus cycles against hand-computed expectations
module tb_qbus_slave_sequencer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0, RBS7 = 1'b0;
  logic [21:0] DAL_in = '0, DAL_out;
  logic DALtx, TRPLY, reg_rd, reg_wr, reg_ack = 1'b1;
  logic [5:0] reg_index;
  logic [15:0] reg_wdata, reg_rdata = 16'o123456;
  int checks = 0, errors = 0;
  int rd_cnt = 0, wr_cnt = 0, trp_hi = 0, trp_rise = 0;
  int rd0, wr0, th0, tr0;
  logic [5:0] rd_idx = '0, wr_idx = '0;
  logic trp_prev = 1'b0;
  logic [21:0] ma [3];
  logic mb [3];
  qbus_slave_sequencer #(.ADDR(22'o774000), .COUNT(4), .IW(6)) dut (
    .clk(clk), .reset_n(reset_n), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RBS7(RBS7),
    .DAL_in(DAL_in), .DAL_out(DAL_out), .DALtx(DALtx), .TRPLY(TRPLY), .reg_index(reg_index),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );
  always #10 clk = ~clk;
  always @(negedge clk) begin
    if (reg_rd) begin
      rd_cnt <= rd_cnt + 1;
      rd_idx <= reg_index;
    end
    if (reg_wr) begin
      wr_cnt <= wr_cnt + 1;
      wr_idx <= reg_index;
    end
    if (TRPLY) trp_hi <= trp_hi + 1;
    if (TRPLY && !trp_prev) trp_rise <= trp_rise + 1;
    trp_prev <= TRPLY;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask
  task automatic bus_addr(input logic [21:0] a, input logic b);
    DAL_in = a;
    RBS7 = b;
    cyc(1);
    RSYNC = 1'b1;
    cyc(3);
  endtask
  task automatic snap();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    th0 = trp_hi;
    tr0 = trp_rise;
  endtask
  initial begin
    cyc(3);
    chk("rst_trply", 32'(TRPLY), 0);
    chk("rst_daltx", 32'(DALtx), 0);
    chk("rst_rd_wr", 32'({reg_rd, reg_wr}), 0);
    chk("rst_dal_out", 32'(DAL_out), 0);
    chk("rst_index", 32'(reg_index), 0);
    reset_n = 1'b1;
    cyc(5);
    // DATI to index 2, ack in the same cycle as reg_rd
    snap();
    bus_addr(22'o774004, 1'b1);
    RDIN = 1'b1;
    cyc(3);
    chk("dati_trply_early", 32'(TRPLY), 0);
    chk("dati_rd_pulse", 32'(reg_rd), 1);
    cyc(1);
    chk("dati_trply", 32'(TRPLY), 1);
    chk("dati_daltx", 32'(DALtx), 1);
    chk("dati_rd_low", 32'(reg_rd), 0);
    chk("dati_dal_out", 32'(DAL_out), 32'o0123456);
    chk("dati_rd_cnt", 32'(rd_cnt - rd0), 1);
    chk("dati_index", 32'(rd_idx), 2);
    RDIN = 1'b0;
    cyc(2);
    chk("dati_trply_hold", 32'(TRPLY), 1);
    cyc(1);
    chk("dati_trply_fall", 32'(TRPLY), 0);
    chk("dati_daltx_fall", 32'(DALtx), 0);
    chk("dati_dal_keep", 32'(DAL_out), 32'o0123456);
    RSYNC = 1'b0;
    cyc(3);
    // DATO to index 3
    snap();
    bus_addr(22'o774006, 1'b1);
    DAL_in = 22'o052525;
    RDOUT = 1'b1;
    cyc(4);
    chk("dato_wr_pulse", 32'(reg_wr), 1);
    chk("dato_trply_early", 32'(TRPLY), 0);
    chk("dato_wdata", 32'(reg_wdata), 32'o052525);
    chk("dato_index", 32'(reg_index), 3);
    cyc(1);
    chk("dato_trply", 32'(TRPLY), 1);
    chk("dato_wr_low", 32'(reg_wr), 0);
    chk("dato_wr_cnt", 32'(wr_cnt - wr0), 1);
    RDOUT = 1'b0;
    cyc(3);
    chk("dato_trply_fall", 32'(TRPLY), 0);
    RSYNC = 1'b0;
    cyc(3);
    // misses: past the window, below base, BS7 clear
    ma[0] = 22'o774010; mb[0] = 1'b1;
    ma[1] = 22'o773776; mb[1] = 1'b1;
    ma[2] = 22'o774000; mb[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      snap();
      bus_addr(ma[i], mb[i]);
      RDIN = (i != 2);
      RDOUT = (i == 2);
      cyc(6);
      chk($sformatf("miss%0d_daltx", i), 32'(DALtx), 0);
      chk($sformatf("miss%0d_rdwr", i), 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 0);
      chk($sformatf("miss%0d_trply", i), 32'(trp_hi - th0), 0);
      RDIN = 1'b0;
      RDOUT = 1'b0;
      RSYNC = 1'b0;
      cyc(3);
    end
    // DATIO on index 1
    snap();
    bus_addr(22'o774002, 1'b1);
    RDIN = 1'b1;
    cyc(4);
    chk("datio_rd_trply", 32'(TRPLY), 1);
    chk("datio_rd_index", 32'(rd_idx), 1);
    RDIN = 1'b0;
    cyc(3);
    chk("datio_rd_fall", 32'(TRPLY), 0);
    DAL_in = 22'o000777;
    RDOUT = 1'b1;
    cyc(5);
    chk("datio_wr_trply", 32'(TRPLY), 1);
    chk("datio_wr_index", 32'(wr_idx), 1);
    chk("datio_wdata", 32'(reg_wdata), 32'o000777);
    RDOUT = 1'b0;
    cyc(3);
    chk("datio_wr_fall", 32'(TRPLY), 0);
    chk("datio_rises", 32'(trp_rise - tr0), 2);
    chk("datio_counts", 32'({8'(rd_cnt - rd0), 8'(wr_cnt - wr0)}), 32'h0101);
    RSYNC = 1'b0;
    cyc(3);
    // abort during RD with no ack, then a late ack
    snap();
    reg_ack = 1'b0;
    bus_addr(22'o774000, 1'b1);
    RDIN = 1'b1;
    cyc(4);
    chk("abort_rd_cnt", 32'(rd_cnt - rd0), 1);
    RSYNC = 1'b0;
    RDIN = 1'b0;
    cyc(10);
    reg_ack = 1'b1;
    cyc(5);
    chk("abort_trply", 32'(trp_hi - th0), 0);
    chk("abort_daltx", 32'(DALtx), 0);
    chk("abort_rd_once", 32'(rd_cnt - rd0), 1);
    // async reset during RDRV, release with SYNC still high
    bus_addr(22'o774004, 1'b1);
    RDIN = 1'b1;
    cyc(5);
    chk("rst6_rdrv", 32'(TRPLY), 1);
    #4 reset_n = 1'b0;
    #1;
    chk("rst6_trply_async", 32'(TRPLY), 0);
    chk("rst6_daltx_async", 32'(DALtx), 0);
    cyc(2);
    snap();
    reset_n = 1'b1;
    cyc(10);
    chk("rst6_ignored", 32'((rd_cnt - rd0) + (trp_hi - th0)), 0);
    RDIN = 1'b0;
    RSYNC = 1'b0;
    cyc(4);
    bus_addr(22'o774004, 1'b1);
    RDIN = 1'b1;
    cyc(4);
    chk("rst6_new_trply", 32'(TRPLY), 1);
    chk("rst6_new_rd", 32'(rd_cnt - rd0), 1);
    RDIN = 1'b0;
    RSYNC = 1'b0;
    cyc(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
